// File: rtl/traffic_phase_sched.sv
// Phase scheduler for a main-road / country-road intersection with pedestrian
// and emergency pre-emption requests. It runs a 1 s prescaler and a BCD countdown.
module traffic_phase_sched #(
   parameter int unsigned CLK_DIV    = 25000000,
   parameter logic [7:0]  T_MAIN_MIN = 8'h59,
   parameter logic [7:0]  T_YELLOW   = 8'h03,
   parameter logic [7:0]  T_SIDE_MAX = 8'h19,
   parameter logic [7:0]  T_CLEAR    = 8'h02
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       car_req,
   input  logic       ped_req,
   input  logic       emg_req,
   output logic       MR,
   output logic       MY,
   output logic       MG,
   output logic       CR,
   output logic       CY,
   output logic       CG,
   output logic       ped_walk,
   output logic       ped_pending,
   output logic [2:0] phase,
   output logic [7:0] sec_cnt,
   output logic       tick
);

   typedef enum logic [2:0] {
      S_MG_MIN  = 3'd0,
      S_MG_IDLE = 3'd1,
      S_MY      = 3'd2,
      S_SG      = 3'd3,
      S_SY      = 3'd4,
      S_EMG     = 3'd5,
      S_CLR     = 3'd6
   } state_t;

   localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   state_t        state, state_n;
   logic [7:0]    sec_n;
   logic          walk_n, pend_n;
   logic [5:0]    lamps_n;
   logic [CW-1:0] div_cnt, div_next;

   // Only ever applied to a nonzero count; 00 is held by the FSM.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] != 4'd0)
         return {v[7:4], v[3:0] - 4'd1};
      else
         return {v[7:4] - 4'd1, 4'd9};
   endfunction

   assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
   assign phase    = state;

   // Prescaler is parked at zero while in (or entering) EMG, so CLR gets full seconds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (state == S_EMG || state_n == S_EMG) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         div_cnt <= div_next;
         tick    <= (div_next == DIV_LAST);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                  <= S_MG_MIN;
         sec_cnt                <= T_MAIN_MIN;
         ped_walk               <= 1'b0;
         ped_pending            <= 1'b0;
         {MR, MY, MG, CR, CY, CG} <= 6'b001100;
      end else begin
         state                  <= state_n;
         sec_cnt                <= sec_n;
         ped_walk               <= walk_n;
         ped_pending            <= pend_n;
         {MR, MY, MG, CR, CY, CG} <= lamps_n;
      end
   end

   always_comb begin
      state_n = state;
      sec_n   = sec_cnt;
      walk_n  = ped_walk;
      pend_n  = ped_pending;

      if (emg_req && state != S_EMG) begin
         state_n = S_EMG;
         sec_n   = 8'h00;
         walk_n  = 1'b0;
      end else begin
         case (state)
            S_MG_MIN: if (tick) begin
               if (sec_cnt == 8'h00) state_n = S_MG_IDLE;
               else                  sec_n   = bcd_dec(sec_cnt);
            end
            S_MG_IDLE: if (tick && (car_req || ped_pending)) begin
               state_n = S_MY;
               sec_n   = T_YELLOW;
            end
            S_MY: if (tick) begin
               if (sec_cnt == 8'h00) begin
                  state_n = S_SG;
                  sec_n   = T_SIDE_MAX;
                  walk_n  = ped_pending;
                  pend_n  = 1'b0;
               end else begin
                  sec_n = bcd_dec(sec_cnt);
               end
            end
            S_SG: if (tick) begin
               if (sec_cnt == 8'h00 || (!car_req && !ped_walk)) begin
                  state_n = S_SY;
                  sec_n   = T_YELLOW;
                  walk_n  = 1'b0;
               end else begin
                  sec_n = bcd_dec(sec_cnt);
               end
            end
            S_SY, S_CLR: if (tick) begin
               if (sec_cnt == 8'h00) begin
                  state_n = S_MG_MIN;
                  sec_n   = T_MAIN_MIN;
               end else begin
                  sec_n = bcd_dec(sec_cnt);
               end
            end
            S_EMG: if (!emg_req) begin
               state_n = S_CLR;
               sec_n   = T_CLEAR;
            end
            default: begin
               state_n = S_MG_MIN;
               sec_n   = T_MAIN_MIN;
               walk_n  = 1'b0;
            end
         endcase
      end

      // A press in the grant cycle survives the clear.
      if (ped_req) pend_n = 1'b1;

      case (state_n)
         S_MG_MIN, S_MG_IDLE: lamps_n = 6'b001100;
         S_MY:                lamps_n = 6'b010100;
         S_SG:                lamps_n = 6'b100001;
         S_SY:                lamps_n = 6'b100010;
         default:             lamps_n = 6'b100100;
      endcase
   end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched with a 4-cycle tick; lamp vectors are
// {MR,MY,MG,CR,CY,CG}.
module tb_traffic_phase_sched;

   localparam int CLK_DIV = 4;
   localparam int TICK_BUDGET = 2 * CLK_DIV + 2;

   localparam logic [5:0] L_MAIN = 6'b001100;
   localparam logic [5:0] L_MY   = 6'b010100;
   localparam logic [5:0] L_SG   = 6'b100001;
   localparam logic [5:0] L_SY   = 6'b100010;
   localparam logic [5:0] L_RED  = 6'b100100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       car_req = 1'b0;
   logic       ped_req = 1'b0;
   logic       emg_req = 1'b0;
   logic       MR, MY, MG, CR, CY, CG;
   logic       ped_walk, ped_pending, tick;
   logic [2:0] phase;
   logic [7:0] sec_cnt;
   logic [5:0] lamps;

   int test_count = 0;
   int fail_count = 0;

   assign lamps = {MR, MY, MG, CR, CY, CG};

   traffic_phase_sched #(
      .CLK_DIV(CLK_DIV),
      .T_MAIN_MIN(8'h59),
      .T_YELLOW(8'h03),
      .T_SIDE_MAX(8'h19),
      .T_CLEAR(8'h02)
   ) dut (
      .clk(clk),
      .rst(rst),
      .car_req(car_req),
      .ped_req(ped_req),
      .emg_req(emg_req),
      .MR(MR),
      .MY(MY),
      .MG(MG),
      .CR(CR),
      .CY(CY),
      .CG(CG),
      .ped_walk(ped_walk),
      .ped_pending(ped_pending),
      .phase(phase),
      .sec_cnt(sec_cnt),
      .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      test_count++;
      assert (obs === exp)
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic car, input logic ped, input logic emg);
      car_req = car;
      ped_req = ped;
      emg_req = emg;
   endtask

   // Returns on the falling edge right after the tick-driven update has landed.
   task automatic waitTick(input string tag);
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < TICK_BUDGET) begin
         @(negedge clk);
         n++;
         if (tick === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         fail_count++;
         $error("[TB] FAIL %s: tick observed 0, expected 1 within %0d cycles", tag, TICK_BUDGET);
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic waitTicks(input int k, input string tag);
      for (int i = 0; i < k; i++) waitTick(tag);
   endtask

   // Holds ped_req high exactly across the edge that consumes the next tick.
   task automatic pressOnTick(input string tag);
      int n;
      n = 0;
      while (tick !== 1'b1 && n < TICK_BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (tick !== 1'b1) begin
         fail_count++;
         $error("[TB] FAIL %s: tick observed 0, expected 1 within %0d cycles", tag, TICK_BUDGET);
      end
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("reset_phase", 8'(phase), 8'd0);
      checkOutput("reset_sec", sec_cnt, 8'h59);
      checkOutput("reset_lamps", 8'(lamps), 8'(L_MAIN));
      checkOutput("reset_walk", 8'(ped_walk), 8'd0);
      checkOutput("reset_pend", 8'(ped_pending), 8'd0);
      checkOutput("reset_tick", 8'(tick), 8'd0);

      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("tick_early", 8'(tick), 8'd0);
      @(negedge clk);
      checkOutput("tick_first", 8'(tick), 8'd1);
      @(negedge clk);
      checkOutput("sec_58", sec_cnt, 8'h58);
      checkOutput("tick_pulse_end", 8'(tick), 8'd0);
      waitTicks(8, "to_50");
      checkOutput("sec_50", sec_cnt, 8'h50);
      waitTick("to_49");
      checkOutput("sec_49_borrow", sec_cnt, 8'h49);
      waitTicks(49, "to_00");
      checkOutput("mgmin_00_phase", 8'(phase), 8'd0);
      checkOutput("mgmin_00_sec", sec_cnt, 8'h00);
      waitTick("to_idle");
      checkOutput("idle_phase", 8'(phase), 8'd1);
      checkOutput("idle_sec", sec_cnt, 8'h00);
      waitTick("idle_hold");
      checkOutput("idle_hold_phase", 8'(phase), 8'd1);

      // Vehicle-driven cycle with early side-green termination.
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitTick("to_my");
      checkOutput("my_phase", 8'(phase), 8'd2);
      checkOutput("my_sec", sec_cnt, 8'h03);
      checkOutput("my_lamps", 8'(lamps), 8'(L_MY));
      waitTicks(3, "my_count");
      checkOutput("my_00", sec_cnt, 8'h00);
      checkOutput("my_00_phase", 8'(phase), 8'd2);
      waitTick("to_sg");
      checkOutput("sg_phase", 8'(phase), 8'd3);
      checkOutput("sg_sec", sec_cnt, 8'h19);
      checkOutput("sg_lamps", 8'(lamps), 8'(L_SG));
      checkOutput("sg_walk_car", 8'(ped_walk), 8'd0);
      waitTicks(4, "sg_count");
      checkOutput("sg_15", sec_cnt, 8'h15);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitTick("sg_early_exit");
      checkOutput("sy_early_phase", 8'(phase), 8'd4);
      checkOutput("sy_early_sec", sec_cnt, 8'h03);
      checkOutput("sy_lamps", 8'(lamps), 8'(L_SY));
      waitTicks(4, "sy_count");
      checkOutput("back_mgmin_phase", 8'(phase), 8'd0);
      checkOutput("back_mgmin_sec", sec_cnt, 8'h59);
      checkOutput("back_mgmin_lamps", 8'(lamps), 8'(L_MAIN));

      // Pedestrian request served with a full side-green.
      applyStimulus(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("ped_latched", 8'(ped_pending), 8'd1);
      waitTicks(60, "ped_mgmin");
      checkOutput("ped_idle_phase", 8'(phase), 8'd1);
      waitTick("ped_to_my");
      checkOutput("ped_my_phase", 8'(phase), 8'd2);
      waitTicks(4, "ped_my");
      checkOutput("ped_sg_phase", 8'(phase), 8'd3);
      checkOutput("ped_sg_walk", 8'(ped_walk), 8'd1);
      checkOutput("ped_sg_pend", 8'(ped_pending), 8'd0);
      waitTicks(19, "ped_sg_full");
      checkOutput("ped_sg_00_phase", 8'(phase), 8'd3);
      checkOutput("ped_sg_00_sec", sec_cnt, 8'h00);
      checkOutput("ped_sg_00_walk", 8'(ped_walk), 8'd1);
      waitTick("ped_to_sy");
      checkOutput("ped_sy_phase", 8'(phase), 8'd4);
      checkOutput("ped_sy_walk", 8'(ped_walk), 8'd0);
      waitTicks(4, "ped_sy");
      checkOutput("ped_back_phase", 8'(phase), 8'd0);

      // Press again on the grant edge: walk granted and request stays latched.
      applyStimulus(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitTicks(61, "grant_mgmin");
      checkOutput("grant_my_phase", 8'(phase), 8'd2);
      waitTicks(3, "grant_my");
      checkOutput("grant_my_00", sec_cnt, 8'h00);
      pressOnTick("grant_edge");
      checkOutput("grant_sg_phase", 8'(phase), 8'd3);
      checkOutput("grant_walk", 8'(ped_walk), 8'd1);
      checkOutput("grant_pend_kept", 8'(ped_pending), 8'd1);

      // Emergency pre-emption mid side-green.
      waitTicks(2, "emg_pre");
      checkOutput("emg_pre_sec", sec_cnt, 8'h17);
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("emg_phase", 8'(phase), 8'd5);
      checkOutput("emg_lamps", 8'(lamps), 8'(L_RED));
      checkOutput("emg_walk", 8'(ped_walk), 8'd0);
      checkOutput("emg_sec", sec_cnt, 8'h00);
      checkOutput("emg_pend_kept", 8'(ped_pending), 8'd1);
      repeat (6) @(negedge clk);
      checkOutput("emg_hold_phase", 8'(phase), 8'd5);
      checkOutput("emg_hold_tick", 8'(tick), 8'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("clr_phase", 8'(phase), 8'd6);
      checkOutput("clr_sec", sec_cnt, 8'h02);
      checkOutput("clr_lamps", 8'(lamps), 8'(L_RED));
      waitTicks(2, "clr_count");
      checkOutput("clr_00", sec_cnt, 8'h00);
      waitTick("clr_exit");
      checkOutput("clr_exit_phase", 8'(phase), 8'd0);
      checkOutput("clr_exit_sec", sec_cnt, 8'h59);

      // Re-assertion during clearance returns to EMG.
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      waitTick("clr2_count");
      checkOutput("clr2_sec", sec_cnt, 8'h01);
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("clr_reemg_phase", 8'(phase), 8'd5);
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("clr3_sec", sec_cnt, 8'h02);
      waitTicks(3, "clr3_count");
      checkOutput("clr3_exit_phase", 8'(phase), 8'd0);

      // Asynchronous reset in the middle of side-yellow.
      waitTicks(61, "final_mgmin");
      checkOutput("final_my_phase", 8'(phase), 8'd2);
      waitTicks(4, "final_my");
      checkOutput("final_sg_pend_clear", 8'(ped_pending), 8'd0);
      waitTicks(20, "final_sg");
      checkOutput("final_sy_phase", 8'(phase), 8'd4);
      waitTick("final_sy");
      checkOutput("final_sy_sec", sec_cnt, 8'h02);
      #3 rst = 1'b1;
      #1;
      checkOutput("async_rst_phase", 8'(phase), 8'd0);
      checkOutput("async_rst_sec", sec_cnt, 8'h59);
      checkOutput("async_rst_lamps", 8'(lamps), 8'(L_MAIN));
      checkOutput("async_rst_walk", 8'(ped_walk), 8'd0);
      checkOutput("async_rst_tick", 8'(tick), 8'd0);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
